// File: rtl/qq_ctrl_if.sv
// Request/operation bus for the QuickQ sequencer.
// The requester/datapath side uses the master modport; the controller uses the slave modport.
interface qq_ctrl_if #(
    parameter int unsigned KW = 16
);
    logic          enq_req;
    logic [KW-1:0] enq_key;
    logic          deq_req;
    logic          req_ready;
    logic [KW-1:0] head_key;
    logic          op_start;
    logic          op_enq;
    logic          op_deq;
    logic [KW-1:0] op_key;
    logic [31:0]   last_addr;
    logic          full;
    logic          empty;
    logic          deq_valid;
    logic [KW-1:0] deq_key;
    logic          err_ovf;
    logic          err_udf;

    modport master (
        output enq_req, enq_key, deq_req, head_key,
        input  req_ready, op_start, op_enq, op_deq, op_key, last_addr, full, empty,
               deq_valid, deq_key, err_ovf, err_udf
    );

    modport slave (
        input  enq_req, enq_key, deq_req, head_key,
        output req_ready, op_start, op_enq, op_deq, op_key, last_addr, full, empty,
               deq_valid, deq_key, err_ovf, err_udf
    );
endinterface

// File: rtl/qq_ctrl.sv
// QuickQ operation sequencer: screens enqueue/dequeue requests against full/empty,
// issues one datapath operation at a time, waits the settle time, then commits occupancy.
module qq_ctrl #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned KW        = 16,
    parameter int unsigned OP_CYCLES = 2
) (
    input logic      clk,
    input logic      rst,
    qq_ctrl_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH + 1);
    localparam int unsigned CW = (OP_CYCLES > 1) ? $clog2(OP_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StCommit} state_t;

    state_t          state;
    logic [AW-1:0]   occ;
    logic [CW-1:0]   cnt;
    logic [KW-1:0]   head_lat;
    logic            is_full;
    logic            is_empty;
    logic            want_enq;
    logic            want_deq;

    // Status follows committed occupancy only; ready depends on state and reset alone.
    assign is_full       = (occ == AW'(DEPTH));
    assign is_empty      = (occ == '0);
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;
    assign bus.last_addr = 32'(occ);
    assign bus.req_ready = (state == StIdle) & ~rst;

    // Screening: a lone enqueue is blocked when full; a replace may proceed when full.
    // Any dequeue half is blocked when empty.
    assign want_enq = bus.enq_req & ~(~bus.deq_req & is_full);
    assign want_deq = bus.deq_req & ~is_empty;

    // Sequencer FSM with registered datapath controls, pulses and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= StIdle;
            occ           <= '0;
            cnt           <= '0;
            head_lat      <= '0;
            bus.op_start  <= 1'b0;
            bus.op_enq    <= 1'b0;
            bus.op_deq    <= 1'b0;
            bus.op_key    <= '0;
            bus.deq_valid <= 1'b0;
            bus.deq_key   <= '0;
            bus.err_ovf   <= 1'b0;
            bus.err_udf   <= 1'b0;
        end else begin
            bus.op_start  <= 1'b0;
            bus.err_ovf   <= 1'b0;
            bus.err_udf   <= 1'b0;
            bus.deq_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.enq_req | bus.deq_req) begin
                        // Rejected halves are consumed here and only flagged.
                        bus.err_ovf <= bus.enq_req & ~bus.deq_req & is_full;
                        bus.err_udf <= bus.deq_req & is_empty;
                        if (want_enq | want_deq) begin
                            state        <= StIssue;
                            bus.op_start <= 1'b1;
                            bus.op_enq   <= want_enq;
                            bus.op_deq   <= want_deq;
                            bus.op_key   <= want_enq ? bus.enq_key : '0;
                            head_lat     <= bus.head_key;
                        end
                    end
                end
                StIssue: begin
                    state <= StWait;
                    cnt   <= CW'(OP_CYCLES - 1);
                end
                StWait: begin
                    if (cnt == '0) begin
                        state         <= StCommit;
                        bus.deq_valid <= bus.op_deq;
                        if (bus.op_deq) begin
                            bus.deq_key <= head_lat;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                StCommit: begin
                    // Replace leaves occupancy unchanged; screening keeps occ in 0..DEPTH.
                    if (bus.op_enq & ~bus.op_deq) begin
                        occ <= occ + AW'(1);
                    end else if (bus.op_deq & ~bus.op_enq) begin
                        occ <= occ - AW'(1);
                    end
                    bus.op_enq <= 1'b0;
                    bus.op_deq <= 1'b0;
                    bus.op_key <= '0;
                    state      <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_qq_ctrl.sv
// Self-checking bench for qq_ctrl: a cycle-index timeline model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_qq_ctrl;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned KW        = 16;
    localparam int unsigned OP_CYCLES = 2;
    localparam int          LAST      = OP_CYCLES + 2;  // cycle index of COMMIT after accept

    logic clk;
    logic rst;
    int   n_asrt = 0;
    int   n_fail = 0;

    qq_ctrl_if #(.KW(KW)) bus ();

    qq_ctrl #(
        .DEPTH    (DEPTH),
        .KW       (KW),
        .OP_CYCLES(OP_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: occupancy plus the number of cycles elapsed since the last accepted operation.
    int          m_occ;
    int          m_k;
    logic        m_enq;
    logic        m_deq;
    logic [KW-1:0] m_key;
    logic [KW-1:0] m_head;
    logic        m_ovf;
    logic        m_udf;
    logic        m_e;
    logic        m_d;

    assign m_e = bus.enq_req && !(!bus.deq_req && m_occ == DEPTH);
    assign m_d = bus.deq_req && m_occ != 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_occ <= 0; m_k <= 0; m_enq <= 0; m_deq <= 0; m_key <= '0; m_head <= '0;
            m_ovf <= 0; m_udf <= 0;
        end else begin
            m_ovf <= 0;
            m_udf <= 0;
            if (m_k == 0) begin
                if (bus.enq_req || bus.deq_req) begin
                    m_ovf <= bus.enq_req && !bus.deq_req && m_occ == DEPTH;
                    m_udf <= bus.deq_req && m_occ == 0;
                    if (m_e || m_d) begin
                        m_k    <= 1;
                        m_enq  <= m_e;
                        m_deq  <= m_d;
                        m_key  <= m_e ? bus.enq_key : '0;
                        m_head <= bus.head_key;
                    end
                end
            end else if (m_k == LAST) begin
                m_occ <= m_occ + (m_enq ? 1 : 0) - (m_deq ? 1 : 0);
                m_k   <= 0;
                m_enq <= 0;
                m_deq <= 0;
                m_key <= '0;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("cmp_req_ready", 32'(bus.req_ready), 32'(m_k == 0 && !rst));
        check("cmp_op_start", 32'(bus.op_start), 32'(m_k == 1));
        check("cmp_op_enq", 32'(bus.op_enq), 32'(m_enq));
        check("cmp_op_deq", 32'(bus.op_deq), 32'(m_deq));
        check("cmp_op_key", 32'(bus.op_key), 32'(m_key));
        check("cmp_last_addr", bus.last_addr, 32'(m_occ));
        check("cmp_full", 32'(bus.full), 32'(m_occ == DEPTH));
        check("cmp_empty", 32'(bus.empty), 32'(m_occ == 0));
        check("cmp_deq_valid", 32'(bus.deq_valid), 32'(m_k == LAST && m_deq));
        check("cmp_err_ovf", 32'(bus.err_ovf), 32'(m_ovf));
        check("cmp_err_udf", 32'(bus.err_udf), 32'(m_udf));
        if (m_k == LAST && m_deq) check("cmp_deq_key", 32'(bus.deq_key), 32'(m_head));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge (E0); returns in cycle c1.
    task automatic issue(input logic e, input logic d, input logic [KW-1:0] key,
                         input logic [KW-1:0] head);
        bus.enq_req  = e;
        bus.deq_req  = d;
        bus.enq_key  = key;
        bus.head_key = head;
        tick();
        bus.enq_req = 1'b0;
        bus.deq_req = 1'b0;
    endtask

    task automatic wait_idle();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst          = 1'b0;
        bus.enq_req  = 1'b0;
        bus.deq_req  = 1'b0;
        bus.enq_key  = '0;
        bus.head_key = '0;
        #1 rst = 1'b1;
        tick();
        tick();
        check("rst_last_addr", bus.last_addr, 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(bus.req_ready), 32'd1);

        // Single enqueue timing.
        issue(1'b1, 1'b0, 16'h0005, 16'h0000);
        check("enq_c1_op_start", 32'(bus.op_start), 32'd1);
        check("enq_c1_op_enq", 32'(bus.op_enq), 32'd1);
        check("enq_c1_op_deq", 32'(bus.op_deq), 32'd0);
        check("enq_c1_op_key", 32'(bus.op_key), 32'h5);
        tick(); tick(); tick();
        check("enq_c4_op_enq", 32'(bus.op_enq), 32'd1);
        check("enq_c4_op_key", 32'(bus.op_key), 32'h5);
        check("enq_c4_ready", 32'(bus.req_ready), 32'd0);
        tick();
        check("enq_c5_last_addr", bus.last_addr, 32'd1);
        check("enq_c5_ready", 32'(bus.req_ready), 32'd1);

        // Fill to capacity, then overflow.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 1'b0, 16'(i + 1), 16'h0000);
            wait_idle();
        end
        check("fill_last_addr", bus.last_addr, 32'd16);
        check("fill_full", 32'(bus.full), 32'd1);
        issue(1'b1, 1'b0, 16'h00AA, 16'h0000);
        check("ovf_err", 32'(bus.err_ovf), 32'd1);
        check("ovf_no_start", 32'(bus.op_start), 32'd0);
        check("ovf_ready", 32'(bus.req_ready), 32'd1);
        tick();
        check("ovf_last_addr", bus.last_addr, 32'd16);

        // Replace on a full queue.
        issue(1'b1, 1'b1, 16'h0009, 16'h0001);
        check("rep_op_enq", 32'(bus.op_enq), 32'd1);
        check("rep_op_deq", 32'(bus.op_deq), 32'd1);
        check("rep_op_key", 32'(bus.op_key), 32'h9);
        check("rep_no_ovf", 32'(bus.err_ovf), 32'd0);
        tick(); tick(); tick();
        check("rep_deq_valid", 32'(bus.deq_valid), 32'd1);
        check("rep_deq_key", 32'(bus.deq_key), 32'h1);
        tick();
        check("rep_last_addr", bus.last_addr, 32'd16);

        // Underflow, then enq+deq on empty.
        do_reset();
        issue(1'b0, 1'b1, 16'h0000, 16'h0000);
        check("udf_err", 32'(bus.err_udf), 32'd1);
        check("udf_no_start", 32'(bus.op_start), 32'd0);
        tick();
        issue(1'b1, 1'b1, 16'h0007, 16'h0000);
        check("both_empty_udf", 32'(bus.err_udf), 32'd1);
        check("both_empty_start", 32'(bus.op_start), 32'd1);
        check("both_empty_enq", 32'(bus.op_enq), 32'd1);
        check("both_empty_deq", 32'(bus.op_deq), 32'd0);
        wait_idle();
        check("both_empty_last", bus.last_addr, 32'd1);

        // Dequeue at last_addr = 3.
        for (int i = 0; i < 2; i++) begin
            issue(1'b1, 1'b0, 16'(i + 2), 16'h0000);
            wait_idle();
        end
        check("pre_deq_last", bus.last_addr, 32'd3);
        issue(1'b0, 1'b1, 16'h0000, 16'h0002);
        tick(); tick(); tick();
        check("deq_valid", 32'(bus.deq_valid), 32'd1);
        check("deq_key", 32'(bus.deq_key), 32'h2);
        tick();
        check("deq_last_addr", bus.last_addr, 32'd2);

        // Reset during WAIT of an enqueue at last_addr = 4.
        for (int i = 0; i < 2; i++) begin
            issue(1'b1, 1'b0, 16'h0010, 16'h0000);
            wait_idle();
        end
        check("pre_rst_last", bus.last_addr, 32'd4);
        issue(1'b1, 1'b0, 16'h0033, 16'h0000);
        tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_op_enq", 32'(bus.op_enq), 32'd0);
        check("midrst_op_key", 32'(bus.op_key), 32'd0);
        check("midrst_last", bus.last_addr, 32'd0);
        check("midrst_ready", 32'(bus.req_ready), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("postrst_ready", 32'(bus.req_ready), 32'd1);
        tick(); tick(); tick();
        check("postrst_last", bus.last_addr, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
